// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin one-hot arbiter.
//   N_DEF, PTR_W_DEF, CNT_W_DEF : default requester count, pointer width and
//                                 grant-counter width.
//   state_e                     : arbiter state encoding (IDLE=0, GRANT=1).
package arb_pkg;

    localparam int N_DEF     = 8;
    localparam int PTR_W_DEF = 3;
    localparam int CNT_W_DEF = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

endpackage : arb_pkg

// File: rtl/rr_pick.sv
// Combinational round-robin winner selection.
// Ports:
//   req           in  [N-1:0]      request vector
//   ptr           in  [PTR_W-1:0]  highest-priority index for this pick
//   any           out             at least one request is set
//   winner_idx    out [PTR_W-1:0]  index of the winning requester
//   winner_onehot out [N-1:0]      winner as a one-hot vector (zero if !any)
module rr_pick #(
    parameter int N     = 8,
    parameter int PTR_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic             any,
    output logic [PTR_W-1:0] winner_idx,
    output logic [N-1:0]     winner_onehot
);

    logic [2*N-1:0]   req_dbl;
    logic [2*N-1:0]   req_shr;
    logic [N-1:0]     req_rot;
    logic [N-1:0]     rot_oh;
    logic [2*N-1:0]   oh_dbl;
    logic [2*N-1:0]   oh_shl;
    logic [PTR_W-1:0] rot_pos;
    logic             found;

    // Rotating right by ptr puts requester ptr at bit 0, so a plain
    // lowest-bit-first scan implements the round-robin order.
    always_comb begin
        req_dbl = {req, req};
        req_shr = req_dbl >> ptr;
        req_rot = req_shr[N-1:0];
    end

    always_comb begin
        found   = 1'b0;
        rot_pos = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && req_rot[i]) begin
                found   = 1'b1;
                rot_pos = PTR_W'(i);
            end
        end
    end

    // Rotate the one-hot result back left by ptr; index addition wraps
    // naturally because N is a power of two.
    always_comb begin
        rot_oh        = found ? (N'(1) << rot_pos) : '0;
        oh_dbl        = {rot_oh, rot_oh};
        oh_shl        = oh_dbl << ptr;
        winner_onehot = oh_shl[2*N-1:N];
        winner_idx    = rot_pos + ptr;
        any           = found;
    end

endmodule : rr_pick

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a registered one-hot grant and valid/ready
// handshake towards the consumer; a saturating counter tracks accepts.
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   req          in   [N-1:0] level-sensitive request vector
//   grant        out  [N-1:0] registered grant, one-hot or zero
//   grant_valid  out  grant holds a valid one-hot word
//   grant_ready  in   consumer accepts the grant this cycle
//   grant_cnt    out  [CNT_W-1:0] accepted-grant count, saturating
//   clr_cnt      in   synchronous clear of grant_cnt (wins over increment)
module rr_onehot_arbiter
    import arb_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int PTR_W = PTR_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic             grant_valid,
    input  logic             grant_ready,
    output logic [CNT_W-1:0] grant_cnt,
    input  logic             clr_cnt
);

    state_e           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] win_q, win_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             pick_any;
    logic [PTR_W-1:0] pick_idx;
    logic [N-1:0]     pick_oh;
    logic             accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    rr_pick #(
        .N     (N),
        .PTR_W (PTR_W)
    ) u_pick (
        .req           (req),
        .ptr           (ptr_q),
        .any           (pick_any),
        .winner_idx    (pick_idx),
        .winner_onehot (pick_oh)
    );

    assign accept = (state_q == ST_GRANT) && grant_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        grant_d = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_oh;
                    win_d   = pick_idx;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Grant is held regardless of req until the consumer takes it.
                if (grant_ready) begin
                    ptr_d   = win_q + PTR_W'(1);
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = (state_q == ST_GRANT);
    assign grant_cnt   = cnt_q;

endmodule : rr_onehot_arbiter

// File: tb/tb_rr_onehot_arbiter.sv
module tb_rr_onehot_arbiter;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  req = '0;
    logic        grant_ready = 1'b0;
    logic        clr_cnt = 1'b0;
    logic [7:0]  grant, grant4;
    logic        grant_valid, valid4;
    logic [15:0] cnt;
    logic [3:0]  cnt4;

    always #5 clk = ~clk;

    rr_onehot_arbiter #(.N(8), .PTR_W(3), .CNT_W(16)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_ready (grant_ready),
        .grant_cnt   (cnt),
        .clr_cnt     (clr_cnt)
    );

    rr_onehot_arbiter #(.N(8), .PTR_W(3), .CNT_W(4)) u_dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .grant       (grant4),
        .grant_valid (valid4),
        .grant_ready (grant_ready),
        .grant_cnt   (cnt4),
        .clr_cnt     (clr_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference model: who holds the grant, where the next scan starts, counts.
    int m_ptr  = 0;
    int m_win  = 0;
    bit m_busy = 1'b0;
    int m_cnt  = 0;
    int m_cnt4 = 0;
    int n_acc  = 0;
    logic [7:0] seq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Encoder stage fed by the grant: index of the set bit.
    function automatic int enc(input logic [7:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_win = 0; m_busy = 1'b0; m_cnt = 0; m_cnt4 = 0;
    endtask

    task automatic model_edge();
        bit acc;
        if (!rst_n) begin
            model_reset();
            return;
        end
        acc = m_busy && grant_ready;
        if (m_busy) begin
            if (grant_ready) begin
                m_ptr  = (m_win + 1) % N;
                m_busy = 1'b0;
                n_acc++;
            end
        end else if (req != 0) begin
            for (int k = 0; k < N; k++) begin
                if (req[(m_ptr + k) % N]) begin
                    m_win  = (m_ptr + k) % N;
                    m_busy = 1'b1;
                    break;
                end
            end
        end
        if (clr_cnt) begin
            m_cnt = 0; m_cnt4 = 0;
        end else if (acc) begin
            m_cnt  = (m_cnt  < 65535) ? m_cnt  + 1 : m_cnt;
            m_cnt4 = (m_cnt4 < 15)    ? m_cnt4 + 1 : m_cnt4;
        end
    endtask

    task automatic check_all();
        logic [7:0] exp_g;
        exp_g = m_busy ? 8'(1 << m_win) : 8'h00;
        chk("grant",   grant,        exp_g);
        chk("valid",   grant_valid,  m_busy);
        chk("cnt",     cnt,          m_cnt);
        chk("grant4",  grant4,       exp_g);
        chk("valid4",  valid4,       m_busy);
        chk("cnt4",    cnt4,         m_cnt4);
        chk("onehot0", $onehot0(grant), 1);
        if (m_busy) chk("enc_y", enc(grant), m_win);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        // Reset with all requests asserted.
        rst_n = 1'b0; req = 8'hFF;
        #12;
        check_all();
        step();
        rst_n = 1'b1;
        step();
        chk("t1_first", grant, 8'h01);

        // Rotation: 16 accepts with ready held high.
        seq.delete();
        if (grant_valid) seq.push_back(grant);
        grant_ready = 1'b1;
        begin
            int start;
            start = n_acc;
            for (int c = 0; c < 40 && (n_acc - start) < 16; c++) begin
                step();
                if (grant_valid) seq.push_back(grant);
            end
        end
        chk("t2_len", seq.size(), 16);
        for (int i = 0; i < 16; i++) begin
            logic [7:0] e;
            e = 8'(1 << (i % 8));
            chk("t2_seq", (i < seq.size()) ? seq[i] : 8'hxx, e);
        end
        chk("t2_cnt", cnt, 16);

        // Backpressure: grant held through req changes.
        req = 8'h24; grant_ready = 1'b0;
        repeat (5) step();
        chk("t3_hold", grant, 8'h04);
        req = 8'h00;
        repeat (3) step();
        chk("t3_hold_noreq", grant, 8'h04);
        chk("t3_valid", grant_valid, 1);
        grant_ready = 1'b1;
        step();
        step();
        chk("t3_idle", grant_valid, 0);

        // Wrap and skip.
        grant_ready = 1'b0; req = 8'h40;
        step();
        chk("t4_g40", grant, 8'h40);
        grant_ready = 1'b1; step();
        req = 8'h41; grant_ready = 1'b0; step();
        chk("t4_wrap", grant, 8'h01);
        grant_ready = 1'b1; step();
        grant_ready = 1'b0; step();
        chk("t4_skip", grant, 8'h40);
        grant_ready = 1'b1; step();
        grant_ready = 1'b0; step();
        chk("t4_wrap2", grant, 8'h01);

        // Counter saturation, then clear beating a same-cycle accept.
        req = 8'hFF; grant_ready = 1'b1;
        repeat (40) step();
        chk("t5_sat", cnt4, 4'hF);
        for (int c = 0; c < 4 && !grant_valid; c++) step();
        chk("t5_pre_valid", grant_valid, 1);
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        chk("t5_clr", cnt, 0);
        chk("t5_clr4", cnt4, 0);

        // Asynchronous reset while a grant is pending.
        grant_ready = 1'b0; req = 8'h28;
        for (int c = 0; c < 4 && !grant_valid; c++) step();
        chk("t6_pre_valid", grant_valid, 1);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_async_grant", grant, 8'h00);
        chk("t6_async_valid", grant_valid, 0);
        check_all();
        step();
        rst_n = 1'b1;
        step();
        chk("t6_first", grant, 8'h08);

        // Randomized traffic against the model.
        repeat (300) begin
            req         = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            grant_ready = 1'($urandom_range(0, 1));
            clr_cnt     = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_rr_onehot_arbiter
